sha3_theta_stage: RTL and testbench

Parametrised, elastic implementation of the complete Keccak θ step. It accepts one 25-lane state per transfer and computes the column parities C[x]. It then derives the θ elements D[x] = C[x−1] ⊕ rol(C[x+1], ROT) and returns state ⊕ D. It sits between the round-state register and the ρ/π stage of the permutation core, and replaces the fixed 64-bit, single-register elt evaluator with one that supports any Keccak-f lane width, selectable pipeline depth, valid/ready flow control and a per-transfer bypass.

---
 rtl/sha3_theta_stage_if.sv | 26 ++
 rtl/sha3_theta_stage.sv | 135 +++++++++++++
 tb/tb_sha3_theta_stage.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sha3_theta_stage_if.sv
// Handshake bundle for sha3_theta_stage: the upstream state transfer and the
// downstream result transfer, with the original port names kept.
interface sha3_theta_stage_if #(
   parameter int unsigned LANE_W = 64
);
   logic                    in_valid;
   logic                    in_ready;
   logic                    in_bypass;
   logic [25*LANE_W-1:0]    in_state;
   logic                    out_valid;
   logic                    out_ready;
   logic [25*LANE_W-1:0]    out_state;
   logic [5*LANE_W-1:0]     out_elt;

   // Environment side: offers states and consumes results.
   modport master (
      output in_valid, in_bypass, in_state, out_ready,
      input  in_ready, out_valid, out_state, out_elt
   );

   // Stage side.
   modport slave (
      input  in_valid, in_bypass, in_state, out_ready,
      output in_ready, out_valid, out_state, out_elt
   );
endinterface

// File: rtl/sha3_theta_stage.sv
// Elastic Keccak theta step: column parities C[x], elements
// D[x] = C[x-1] ^ rol(C[x+1], ROT), result state ^ D, with optional bypass.
// One or two register stages with valid/ready flow control and no skid buffer.
module sha3_theta_stage #(
   parameter int unsigned LANE_W = 64,
   parameter int unsigned ROT    = 1,
   parameter int unsigned PIPE   = 2
) (
   input logic               clk,
   input logic               rstn,
   sha3_theta_stage_if.slave bus
);
   localparam int unsigned SW  = 25 * LANE_W;
   localparam int unsigned EW  = 5 * LANE_W;
   localparam int unsigned RSH = (LANE_W - ROT) % LANE_W;

   if (!(LANE_W == 8 || LANE_W == 16 || LANE_W == 32 || LANE_W == 64)) begin : g_bad_lane_w
      $error("sha3_theta_stage: LANE_W must be 8, 16, 32 or 64");
   end
   if (ROT >= LANE_W) begin : g_bad_rot
      $error("sha3_theta_stage: ROT must be below LANE_W");
   end
   if (!(PIPE == 1 || PIPE == 2)) begin : g_bad_pipe
      $error("sha3_theta_stage: PIPE must be 1 or 2");
   end

   function automatic logic [LANE_W-1:0] rol_lane(input logic [LANE_W-1:0] v);
      return (v << ROT) | (v >> RSH);
   endfunction

   function automatic logic [EW-1:0] column_parity(input logic [SW-1:0] st);
      logic [EW-1:0] c;
      c = '0;
      for (int unsigned i = 0; i < 25; i++) begin
         c[(i % 5)*LANE_W +: LANE_W] = c[(i % 5)*LANE_W +: LANE_W] ^ st[i*LANE_W +: LANE_W];
      end
      return c;
   endfunction

   function automatic logic [EW-1:0] theta_elt(input logic [EW-1:0] c);
      logic [EW-1:0] d;
      d = '0;
      for (int unsigned x = 0; x < 5; x++) begin
         d[x*LANE_W +: LANE_W] = c[((x + 4) % 5)*LANE_W +: LANE_W]
                               ^ rol_lane(c[((x + 1) % 5)*LANE_W +: LANE_W]);
      end
      return d;
   endfunction

   function automatic logic [SW-1:0] apply_elt(input logic [SW-1:0] st, input logic [EW-1:0] d);
      logic [SW-1:0] o;
      o = '0;
      for (int unsigned i = 0; i < 25; i++) begin
         o[i*LANE_W +: LANE_W] = st[i*LANE_W +: LANE_W] ^ d[(i % 5)*LANE_W +: LANE_W];
      end
      return o;
   endfunction

   // Last (output) stage, shared by both depths.
   logic          last_valid;
   logic          last_ready;
   logic [SW-1:0] last_state;
   logic [EW-1:0] last_elt;

   assign last_ready    = !last_valid || bus.out_ready;
   assign bus.out_valid = last_valid;
   assign bus.out_state = last_state;
   assign bus.out_elt   = last_elt;

   if (PIPE == 2) begin : g_pipe2
      logic          s1_valid;
      logic          s1_ready;
      logic          s1_bypass;
      logic [SW-1:0] s1_state;
      logic [EW-1:0] s1_c;
      logic [EW-1:0] s1_elt;

      assign s1_ready     = !s1_valid || last_ready;
      assign bus.in_ready = s1_ready;
      // A bypassed transfer carries a zero element so the XOR leaves the state untouched.
      assign s1_elt       = s1_bypass ? '0 : theta_elt(s1_c);

      // Stage 1: column parities captured alongside the raw state and bypass flag.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            s1_valid  <= 1'b0;
            s1_bypass <= 1'b0;
            s1_state  <= '0;
            s1_c      <= '0;
         end else if (s1_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
               s1_c      <= column_parity(bus.in_state);
               s1_state  <= bus.in_state;
               s1_bypass <= bus.in_bypass;
            end
         end
      end

      // Stage 2: element derivation and state update; data moves only with valid content.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            last_valid <= 1'b0;
            last_state <= '0;
            last_elt   <= '0;
         end else if (last_ready) begin
            last_valid <= s1_valid;
            if (s1_valid) begin
               last_elt   <= s1_elt;
               last_state <= apply_elt(s1_state, s1_elt);
            end
         end
      end
   end else begin : g_pipe1
      logic [EW-1:0] in_elt;

      assign bus.in_ready = last_ready;
      assign in_elt       = bus.in_bypass ? '0 : theta_elt(column_parity(bus.in_state));

      // Single stage: full theta evaluated combinationally ahead of the register.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            last_valid <= 1'b0;
            last_state <= '0;
            last_elt   <= '0;
         end else if (last_ready) begin
            last_valid <= bus.in_valid;
            if (bus.in_valid) begin
               last_elt   <= in_elt;
               last_state <= apply_elt(bus.in_state, in_elt);
            end
         end
      end
   end
endmodule

// File: tb/tb_sha3_theta_stage.sv
// Bench for sha3_theta_stage: directed vector table (impulse, rotate wrap,
// bypass), backpressure stream, reset mid-flight and PIPE=1 streaming.
module tb_sha3_theta_stage;
   typedef longint unsigned lanes_t [25];
   typedef longint unsigned elt_t [5];
   typedef struct {
      string  name;
      int     cfg;      // 0: 64-bit PIPE=2 instance, 1: 8-bit PIPE=2 instance
      bit     byp;
      lanes_t st;
      lanes_t exp_st;
      elt_t   exp_elt;
   } vec_t;

   logic clk  = 1'b0;
   logic rstn = 1'b0;
   int   ntests = 0;
   int   nfail  = 0;

   always #5 clk = ~clk;

   sha3_theta_stage_if #(.LANE_W(64)) bus64 ();
   sha3_theta_stage_if #(.LANE_W(8))  bus8 ();
   sha3_theta_stage_if #(.LANE_W(64)) busp1 ();

   sha3_theta_stage #(.LANE_W(64), .ROT(1), .PIPE(2)) dut64 (.clk(clk), .rstn(rstn), .bus(bus64));
   sha3_theta_stage #(.LANE_W(8),  .ROT(1), .PIPE(2)) dut8  (.clk(clk), .rstn(rstn), .bus(bus8));
   sha3_theta_stage #(.LANE_W(64), .ROT(1), .PIPE(1)) dutp1 (.clk(clk), .rstn(rstn), .bus(busp1));

   // ---------------- reference model: lane arrays, bitwise rotation ----------------
   function automatic void theta_ref(input lanes_t a, input int w, input int r, input bit byp,
                                     output lanes_t o, output elt_t d);
      longint unsigned c [5];
      longint unsigned rv;
      longint unsigned mask;
      mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
      for (int x = 0; x < 5; x++) begin
         c[x] = 0;
         for (int y = 0; y < 5; y++) c[x] = c[x] ^ a[x + 5*y];
      end
      for (int x = 0; x < 5; x++) begin
         rv = 0;
         for (int b = 0; b < w; b++)
            if (c[(x + 1) % 5][b]) rv[(b + r) % w] = 1'b1;
         d[x] = byp ? 64'd0 : ((c[(x + 4) % 5] ^ rv) & mask);
      end
      for (int i = 0; i < 25; i++) o[i] = a[i] ^ d[i % 5];
   endfunction

   function automatic logic [1599:0] pack64(input lanes_t l);
      logic [1599:0] v;
      for (int i = 0; i < 25; i++) v[i*64 +: 64] = l[i];
      return v;
   endfunction

   function automatic logic [199:0] pack8(input lanes_t l);
      logic [199:0]    v;
      longint unsigned t;
      for (int i = 0; i < 25; i++) begin
         t = l[i];
         v[i*8 +: 8] = t[7:0];
      end
      return v;
   endfunction

   function automatic void unpack_st(input logic [1599:0] v, input int w, output lanes_t l);
      for (int i = 0; i < 25; i++) begin
         l[i] = 0;
         for (int b = 0; b < w; b++) l[i][b] = v[i*w + b];
      end
   endfunction

   function automatic void unpack_elt(input logic [319:0] v, input int w, output elt_t e);
      for (int x = 0; x < 5; x++) begin
         e[x] = 0;
         for (int b = 0; b < w; b++) e[x][b] = v[x*w + b];
      end
   endfunction

   function automatic void rand_lanes(output lanes_t l);
      for (int i = 0; i < 25; i++) l[i] = {$urandom(), $urandom()};
   endfunction

   // ---------------- comparison helpers ----------------
   function automatic void chk_bit(input string nm, input logic got, input logic exp);
      ntests++;
      if (got !== exp) begin
         nfail++;
         $display("FAIL %s: got %0b, expected %0b", nm, got, exp);
      end
   endfunction

   function automatic void chk_int(input string nm, input int got, input int exp);
      ntests++;
      if (got != exp) begin
         nfail++;
         $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
      end
   endfunction

   function automatic void chk_lanes(input string nm, input lanes_t got, input lanes_t exp);
      int bad;
      bad = -1;
      ntests++;
      for (int i = 0; i < 25; i++) if (bad < 0 && got[i] != exp[i]) bad = i;
      if (bad >= 0) begin
         nfail++;
         $display("FAIL %s: lane %0d got %h, expected %h", nm, bad, got[bad], exp[bad]);
      end
   endfunction

   function automatic void chk_elt(input string nm, input elt_t got, input elt_t exp);
      int bad;
      bad = -1;
      ntests++;
      for (int x = 0; x < 5; x++) if (bad < 0 && got[x] != exp[x]) bad = x;
      if (bad >= 0) begin
         nfail++;
         $display("FAIL %s: D[%0d] got %h, expected %h", nm, bad, got[bad], exp[bad]);
      end
   endfunction

   // One isolated transfer on instance cfg; returns outputs and latency in cycles.
   task automatic run_vec(input int cfg, input lanes_t st, input bit byp,
                          output lanes_t got, output elt_t gelt, output int lat);
      logic          ov;
      logic [1599:0] sv;
      logic [319:0]  ev;
      @(negedge clk);
      if (cfg == 0) begin
         bus64.in_state = pack64(st); bus64.in_bypass = byp; bus64.in_valid = 1'b1; bus64.out_ready = 1'b1;
      end else begin
         bus8.in_state = pack8(st); bus8.in_bypass = byp; bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
      end
      #1;
      chk_bit("vec_in_ready", (cfg == 0) ? bus64.in_ready : bus8.in_ready, 1'b1);
      @(negedge clk);
      bus64.in_valid = 1'b0;
      bus8.in_valid  = 1'b0;
      lat = 1;
      ov = (cfg == 0) ? bus64.out_valid : bus8.out_valid;
      while (!ov && lat < 20) begin
         @(negedge clk);
         lat++;
         ov = (cfg == 0) ? bus64.out_valid : bus8.out_valid;
      end
      sv = '0;
      ev = '0;
      if (cfg == 0) begin
         sv = bus64.out_state; ev = bus64.out_elt;
      end else begin
         sv[199:0] = bus8.out_state; ev[39:0] = bus8.out_elt;
      end
      unpack_st(sv, (cfg == 0) ? 64 : 8, got);
      unpack_elt(ev, (cfg == 0) ? 64 : 8, gelt);
   endtask

   // ---------------- shared bench state ----------------
   vec_t          tbl [3];
   lanes_t        got_st;
   elt_t          got_elt;
   int            lat;
   lanes_t        bq [6];
   lanes_t        bexp_st [6];
   elt_t          bexp_elt [6];
   lanes_t        pq [100];
   lanes_t        pexp_st [100];
   elt_t          pexp_elt [100];
   bit            pbyp;
   int            sent, recv;
   bit            prev_stall, saw_block;
   logic          orr;
   logic [1599:0] snap_st;
   logic [319:0]  snap_elt;
   lanes_t        tmp_st;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bus64.in_valid = 1'b0; bus64.in_bypass = 1'b0; bus64.in_state = '0; bus64.out_ready = 1'b0;
      bus8.in_valid  = 1'b0; bus8.in_bypass  = 1'b0; bus8.in_state  = '0; bus8.out_ready  = 1'b0;
      busp1.in_valid = 1'b0; busp1.in_bypass = 1'b0; busp1.in_state = '0; busp1.out_ready = 1'b0;

      // ---- directed table ----
      for (int v = 0; v < 3; v++) begin
         for (int i = 0; i < 25; i++) begin
            tbl[v].st[i] = 0;
            tbl[v].exp_st[i] = 0;
         end
         for (int x = 0; x < 5; x++) tbl[v].exp_elt[x] = 0;
      end
      tbl[0].name = "impulse"; tbl[0].cfg = 0; tbl[0].byp = 1'b0;
      tbl[0].st[0] = 1;
      for (int y = 0; y < 5; y++) begin
         tbl[0].exp_st[1 + 5*y] = 1;
         tbl[0].exp_st[4 + 5*y] = 2;
      end
      tbl[0].exp_st[0]  = 1;
      tbl[0].exp_elt[1] = 1;
      tbl[0].exp_elt[4] = 2;

      tbl[1].name = "rot_wrap"; tbl[1].cfg = 1; tbl[1].byp = 1'b0;
      tbl[1].st[1] = 64'h80;
      for (int y = 0; y < 5; y++) begin
         tbl[1].exp_st[0 + 5*y] = 64'h01;
         tbl[1].exp_st[2 + 5*y] = 64'h80;
      end
      tbl[1].exp_st[1]  = 64'h80;
      tbl[1].exp_elt[0] = 64'h01;
      tbl[1].exp_elt[2] = 64'h80;

      tbl[2].name = "bypass"; tbl[2].cfg = 0; tbl[2].byp = 1'b1;
      tbl[2].st[0] = 1;
      tbl[2].exp_st[0] = 1;

      // ---- reset state ----
      rstn = 1'b0;
      repeat (3) @(negedge clk);
      rstn = 1'b1;
      #1;
      chk_bit("rst_out_valid64", bus64.out_valid, 1'b0);
      chk_bit("rst_in_ready64",  bus64.in_ready,  1'b1);
      chk_bit("rst_out_state64", bus64.out_state == '0, 1'b1);
      chk_bit("rst_out_elt64",   bus64.out_elt == '0, 1'b1);
      chk_bit("rst_out_valid8",  bus8.out_valid,  1'b0);
      chk_bit("rst_in_ready8",   bus8.in_ready,   1'b1);
      chk_bit("rst_out_validp1", busp1.out_valid, 1'b0);
      chk_bit("rst_in_readyp1",  busp1.in_ready,  1'b1);
      chk_bit("rst_out_statep1", busp1.out_state == '0, 1'b1);

      for (int v = 0; v < 3; v++) begin
         run_vec(tbl[v].cfg, tbl[v].st, tbl[v].byp, got_st, got_elt, lat);
         chk_int({tbl[v].name, "_latency"}, lat, 2);
         chk_lanes({tbl[v].name, "_state"}, got_st, tbl[v].exp_st);
         chk_elt({tbl[v].name, "_elt"}, got_elt, tbl[v].exp_elt);
      end
      @(negedge clk);
      bus64.out_ready = 1'b0;
      bus8.out_ready  = 1'b0;

      // ---- backpressure: 6 states, out_ready low for 4 cycles mid-stream ----
      for (int n = 0; n < 6; n++) begin
         rand_lanes(bq[n]);
         theta_ref(bq[n], 64, 1, 1'b0, bexp_st[n], bexp_elt[n]);
      end
      sent = 0; recv = 0; prev_stall = 1'b0; saw_block = 1'b0;
      for (int k = 0; k < 60 && recv < 6; k++) begin
         @(negedge clk);
         orr = !(k >= 2 && k < 6);
         bus64.out_ready = orr;
         if (sent < 6) begin
            bus64.in_valid = 1'b1; bus64.in_bypass = 1'b0; bus64.in_state = pack64(bq[sent]);
         end else begin
            bus64.in_valid = 1'b0;
         end
         #1;
         if (bus64.out_valid && !orr) begin
            if (prev_stall)
               chk_bit("bp_stall_stable", (bus64.out_state == snap_st) && (bus64.out_elt == snap_elt), 1'b1);
            snap_st    = bus64.out_state;
            snap_elt   = bus64.out_elt;
            prev_stall = 1'b1;
         end else begin
            prev_stall = 1'b0;
         end
         if (!orr) begin
            chk_bit("bp_in_ready", bus64.in_ready, (sent - recv) < 2);
            if (!bus64.in_ready) saw_block = 1'b1;
         end
         if (bus64.out_valid && orr) begin
            unpack_st(bus64.out_state, 64, got_st);
            unpack_elt(bus64.out_elt, 64, got_elt);
            chk_lanes("bp_state", got_st, bexp_st[recv]);
            chk_elt("bp_elt", got_elt, bexp_elt[recv]);
            recv++;
         end
         if (bus64.in_valid && bus64.in_ready) sent++;
      end
      bus64.in_valid = 1'b0;
      chk_int("bp_sent", sent, 6);
      chk_int("bp_recv", recv, 6);
      chk_bit("bp_in_ready_fell", saw_block, 1'b1);
      @(negedge clk);
      #1;
      chk_bit("bp_no_extra_output", bus64.out_valid, 1'b0);

      // ---- reset mid-flight ----
      @(negedge clk);
      bus64.out_ready = 1'b0;
      rand_lanes(tmp_st);
      bus64.in_valid = 1'b1; bus64.in_state = pack64(tmp_st);
      @(negedge clk);
      rand_lanes(tmp_st);
      bus64.in_state = pack64(tmp_st);
      @(negedge clk);
      bus64.in_valid = 1'b0;
      #1;
      chk_bit("rmf_inflight", bus64.out_valid, 1'b1);
      rstn = 1'b0;
      @(negedge clk);
      rstn = 1'b1;
      bus64.out_ready = 1'b1;
      for (int k = 0; k < 8; k++) begin
         #1;
         chk_bit("rmf_out_valid", bus64.out_valid, 1'b0);
         chk_bit("rmf_in_ready", bus64.in_ready, 1'b1);
         @(negedge clk);
      end

      // ---- PIPE=1 full-throughput stream ----
      busp1.out_ready = 1'b1;
      for (int k = 0; k <= 100; k++) begin
         @(negedge clk);
         if (k < 100) begin
            rand_lanes(pq[k]);
            pbyp = ($urandom_range(0, 7) == 0);
            theta_ref(pq[k], 64, 1, pbyp, pexp_st[k], pexp_elt[k]);
            busp1.in_valid = 1'b1; busp1.in_bypass = pbyp; busp1.in_state = pack64(pq[k]);
         end else begin
            busp1.in_valid = 1'b0;
         end
         #1;
         chk_bit("p1_in_ready", busp1.in_ready, 1'b1);
         chk_bit("p1_out_valid", busp1.out_valid, k >= 1);
         if (k >= 1 && busp1.out_valid) begin
            unpack_st(busp1.out_state, 64, got_st);
            unpack_elt(busp1.out_elt, 64, got_elt);
            chk_lanes("p1_state", got_st, pexp_st[k-1]);
            chk_elt("p1_elt", got_elt, pexp_elt[k-1]);
         end
      end
      @(negedge clk);
      #1;
      chk_bit("p1_drained", busp1.out_valid, 1'b0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end
endmodule
